// File: rtl/ray_hit_reducer_pkg.sv
// ---------------------------------------------------------------------------
// ray_hit_reducer_pkg
//   Shared types for the ray hit reducer: fixed-point distance type, the
//   per-lane HitData record, the reducer FSM state enum and small helpers.
//   fixed_t is a signed Q16.16 value; fixed_inf() is the largest positive
//   value and stands for "no hit yet".
// ---------------------------------------------------------------------------
package ray_hit_reducer_pkg;

   localparam int BVH_AABB_TEST_UNIT_SIZE = 4;
   localparam int FIXED_W                 = 32;
   localparam int PRIM_ID_W               = 16;

   typedef logic signed [FIXED_W-1:0] fixed_t;

   typedef struct packed {
      logic                 b_hit;
      fixed_t               t;
      logic [PRIM_ID_W-1:0] prim_id;
   } hit_data_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DRAIN,
      ST_FLUSH,
      ST_DONE
   } ray_hit_reduce_state_t;

   function automatic fixed_t fixed_inf();
      return {1'b0, {(FIXED_W-1){1'b1}}};
   endfunction

   // Signed a > b.
   function automatic logic fixed_greater(input fixed_t a, input fixed_t b);
      return a > b;
   endfunction

   function automatic hit_data_t no_hit();
      hit_data_t h;
      h.b_hit   = 1'b0;
      h.t       = fixed_inf();
      h.prim_id = '0;
      return h;
   endfunction

endpackage

// File: rtl/ray_hit_reducer_hit_lane_min.sv
// ---------------------------------------------------------------------------
// ray_hit_reducer_hit_lane_min
//   Combinational closest-hit selection over LANES HitData entries.
//   A lane is a candidate when b_hit=1 and (if USE_TMAX) t < tmax. The
//   winner has the strictly smallest t; equal t keeps the lower lane.
//   Outputs no_hit() when there is no candidate.
// Ports
//   hits  in  hit_data_t[LANES]  lane results
//   tmax  in  fixed_t            exclusive upper bound on t (USE_TMAX=1)
//   best  out hit_data_t         selected hit
// ---------------------------------------------------------------------------
module ray_hit_reducer_hit_lane_min
   import ray_hit_reducer_pkg::*;
#(
   parameter int LANES    = BVH_AABB_TEST_UNIT_SIZE,
   parameter bit USE_TMAX = 1'b1
) (
   input  hit_data_t [LANES-1:0] hits,
   input  fixed_t                tmax,
   output hit_data_t             best
);

   always_comb begin
      // NOTE: assign a default before any condition so every path drives
      // best and no latch is inferred; blocking '=' is correct in comb logic.
      best = no_hit();
      for (int i = 0; i < LANES; i++) begin
         // Strict compare: a later lane with equal t never displaces an earlier one.
         if (hits[i].b_hit &&
             (!USE_TMAX || fixed_greater(tmax, hits[i].t)) &&
             (!best.b_hit || fixed_greater(best.t, hits[i].t))) begin
            best = hits[i];
         end
      end
   end

endmodule

// File: rtl/ray_hit_reducer.sv
// ---------------------------------------------------------------------------
// ray_hit_reducer
//   Sequential closest-hit / any-hit reducer for one ray. Accepts a stream of
//   LANES-wide hit batches, reduces each batch into stage S1, merges S1 into
//   a running accumulator and returns one result per ray.
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   start_valid/start_ready    job request handshake (ready only in IDLE)
//   start_anyhit, start_tmax   job mode and exclusive t limit
//   in_valid/in_ready          hit batch handshake
//   in_hits, in_last           batch lanes, final-batch flag
//   terminate                  1-cycle pulse when any-hit mode found a hit
//   out_valid/out_ready        result handshake
//   out_hit, out_beats         best hit, accepted batch count (saturating)
// ---------------------------------------------------------------------------
module ray_hit_reducer
   import ray_hit_reducer_pkg::*;
#(
   parameter int LANES      = BVH_AABB_TEST_UNIT_SIZE,
   parameter int BEAT_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic                  start_anyhit,
   input  fixed_t                start_tmax,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  hit_data_t [LANES-1:0] in_hits,
   input  logic                  in_last,
   output logic                  terminate,
   output logic                  out_valid,
   input  logic                  out_ready,
   output hit_data_t             out_hit,
   output logic [BEAT_CNT_W-1:0] out_beats
);

   ray_hit_reduce_state_t state;
   logic                  anyhit_mode;
   fixed_t                tmax_q;
   logic                  s1_valid;
   hit_data_t             s1_hit;
   hit_data_t             acc;
   hit_data_t             beat_hit;
   hit_data_t             merged_hit;
   hit_data_t [1:0]       merge_in;

   logic start_fire;
   logic in_accept;
   logic stop_anyhit;
   logic s1_load;

   assign start_fire  = start_valid && start_ready;
   assign in_accept   = in_valid && in_ready;
   // S1 only ever holds gated candidates, so b_hit alone means "hit found".
   assign stop_anyhit = (state == ST_ACCUM) && anyhit_mode && s1_valid && s1_hit.b_hit;
   // The beat accepted in the cycle any-hit stops is already a discarded one.
   assign s1_load     = in_accept && (state == ST_ACCUM) && !stop_anyhit;

   ray_hit_reducer_hit_lane_min #(
      .LANES    (LANES),
      .USE_TMAX (1'b1)
   ) u_beat_min (
      .hits (in_hits),
      .tmax (tmax_q),
      .best (beat_hit)
   );

   // Lane 0 = accumulator, so an equal-t S1 hit keeps the earlier beat.
   assign merge_in[0] = acc;
   assign merge_in[1] = s1_hit;

   ray_hit_reducer_hit_lane_min #(
      .LANES    (2),
      .USE_TMAX (1'b0)
   ) u_merge_min (
      .hits (merge_in),
      .tmax (fixed_inf()),
      .best (merged_hit)
   );

   assign out_hit = acc;

   // Control FSM with registered handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         start_ready <= 1'b1;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         terminate   <= 1'b0;
         anyhit_mode <= 1'b0;
         tmax_q      <= '0;
      end else begin
         // NOTE: non-blocking '<=' in clocked blocks so every register samples
         // pre-edge values regardless of statement order.
         terminate <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_fire) begin
                  anyhit_mode <= start_anyhit;
                  tmax_q      <= start_tmax;
                  start_ready <= 1'b0;
                  in_ready    <= 1'b1;
                  state       <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               terminate <= stop_anyhit;
               if (in_accept && in_last) begin
                  in_ready <= 1'b0;
                  state    <= ST_FLUSH;
               end else if (stop_anyhit) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (in_accept && in_last) begin
                  in_ready <= 1'b0;
                  state    <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               out_valid <= 1'b1;
               state     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  start_ready <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               in_ready    <= 1'b0;
               out_valid   <= 1'b0;
               start_ready <= 1'b1;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

   // Datapath: S1 stage, accumulator merge, beat counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the payload registers are reset as well; out_hit is a port
         // that must read as "no hit" straight out of reset.
         s1_valid  <= 1'b0;
         s1_hit    <= no_hit();
         acc       <= no_hit();
         out_beats <= '0;
      end else begin
         if (start_fire) begin
            acc       <= no_hit();
            out_beats <= '0;
         end else begin
            if (s1_valid) begin
               acc <= merged_hit;
            end
            if (in_accept && (out_beats != '1)) begin
               out_beats <= out_beats + BEAT_CNT_W'(1);
            end
         end
         s1_valid <= s1_load;
         if (s1_load) begin
            s1_hit <= beat_hit;
         end
      end
   end

endmodule

// File: tb/tb_ray_hit_reducer.sv
// ---------------------------------------------------------------------------
// tb_ray_hit_reducer
//   Directed bench for ray_hit_reducer with hand-computed expected results.
//   Inputs change 1 ns after the rising edge; outputs are read at that point.
// ---------------------------------------------------------------------------
module tb_ray_hit_reducer;
   import ray_hit_reducer_pkg::*;

   localparam int LANES      = 4;
   localparam int BEAT_CNT_W = 8;

   typedef hit_data_t [LANES-1:0] beat_t;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start_valid;
   logic                  start_ready;
   logic                  start_anyhit;
   fixed_t                start_tmax;
   logic                  in_valid;
   logic                  in_ready;
   beat_t                 in_hits;
   logic                  in_last;
   logic                  terminate;
   logic                  out_valid;
   logic                  out_ready;
   hit_data_t             out_hit;
   logic [BEAT_CNT_W-1:0] out_beats;

   int n_checks = 0;
   int n_pass   = 0;
   int term_cnt = 0;
   int term_base;

   ray_hit_reducer #(
      .LANES      (LANES),
      .BEAT_CNT_W (BEAT_CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .start_anyhit (start_anyhit),
      .start_tmax   (start_tmax),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_hits      (in_hits),
      .in_last      (in_last),
      .terminate    (terminate),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_hit      (out_hit),
      .out_beats    (out_beats)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (terminate) term_cnt++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic hit_data_t mk(input logic b, input int t, input int id);
      hit_data_t h;
      h.b_hit   = b;
      h.t       = fixed_t'(t * 65536);
      h.prim_id = PRIM_ID_W'(id);
      return h;
   endfunction

   function automatic beat_t beat4(input hit_data_t h0, input hit_data_t h1,
                                   input hit_data_t h2, input hit_data_t h3);
      beat_t b;
      b[0] = h0; b[1] = h1; b[2] = h2; b[3] = h3;
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic anyhit, input fixed_t tmax);
      int n = 0;
      start_valid  = 1'b1;
      start_anyhit = anyhit;
      start_tmax   = tmax;
      while (!start_ready && n < 20) begin tick(); n++; end
      if (!start_ready) check("start_ready_timeout", 64'(start_ready), 64'(1));
      tick();
      start_valid = 1'b0;
   endtask

   // Presents one beat and returns 1 ns after the edge that accepted it.
   task automatic send_beat(input beat_t h, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_hits  = h;
      in_last  = last;
      while (!in_ready && n < 20) begin tick(); n++; end
      if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      check({tag, "_out_valid"}, 64'(out_valid), 64'(1));
   endtask

   task automatic take_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   hit_data_t none;
   fixed_t    inf_t;

   initial begin
      none         = mk(1'b0, 1, 0);
      inf_t        = fixed_inf();
      reset        = 1'b1;
      start_valid  = 1'b0;
      start_anyhit = 1'b0;
      start_tmax   = '0;
      in_valid     = 1'b0;
      in_hits      = '0;
      in_last      = 1'b0;
      out_ready    = 1'b0;
      repeat (2) tick();

      // Reset state
      check("rst_start_ready", 64'(start_ready), 64'(1));
      check("rst_in_ready",    64'(in_ready),    64'(0));
      check("rst_out_valid",   64'(out_valid),   64'(0));
      check("rst_terminate",   64'(terminate),   64'(0));
      check("rst_out_hit",     64'(out_hit),     64'(no_hit()));
      check("rst_out_beats",   64'(out_beats),   64'(0));
      reset = 1'b0;
      tick();

      // 1: single beat, lane tie -> lane1 (id 11), bHit=0 lane with T=1 ignored
      start_job(1'b0, inf_t);
      check("t1_in_ready", 64'(in_ready), 64'(1));
      send_beat(beat4(mk(1, 5, 10), mk(1, 3, 11), mk(0, 1, 12), mk(1, 3, 13)), 1'b1);
      check("t1_lat_n1", 64'(out_valid), 64'(0));
      tick();
      check("t1_lat_n2",   64'(out_valid),   64'(1));
      check("t1_hit",      64'(out_hit),     64'(mk(1, 3, 11)));
      check("t1_beats",    64'(out_beats),   64'(1));
      check("t1_start_rdy_busy", 64'(start_ready), 64'(0));
      take_out();
      check("t1_out_valid_clr", 64'(out_valid),   64'(0));
      check("t1_start_rdy",     64'(start_ready), 64'(1));

      // 2: three beats, best per beat {7,2,2}; equal-T later beat must not win
      start_job(1'b0, inf_t);
      send_beat(beat4(mk(1, 7, 20), mk(1, 9, 21), none, none), 1'b0);
      send_beat(beat4(mk(1, 6, 31), none, none, mk(1, 2, 30)), 1'b0);
      send_beat(beat4(mk(1, 2, 40), mk(1, 8, 41), none, none), 1'b1);
      wait_out("t2");
      check("t2_hit",   64'(out_hit),   64'(mk(1, 2, 30)));
      check("t2_beats", 64'(out_beats), 64'(3));
      take_out();

      // 2b: signed compare, negative T beats positive T
      start_job(1'b0, inf_t);
      send_beat(beat4(mk(1, 1, 76), mk(1, -2, 75), none, none), 1'b1);
      wait_out("t2b");
      check("t2b_hit", 64'(out_hit), 64'(mk(1, -2, 75)));
      take_out();

      // 3: any-hit, hit found in beat1, beats 2..5 carry nearer hits but are discarded
      term_base = term_cnt;
      start_job(1'b1, inf_t);
      send_beat(beat4(none, none, none, none), 1'b0);
      send_beat(beat4(none, none, mk(1, 4, 52), none), 1'b0);
      for (int i = 2; i <= 5; i++) begin
         send_beat(beat4(mk(1, 1, 60 + i), none, none, none), (i == 5));
      end
      wait_out("t3");
      check("t3_hit",       64'(out_hit),             64'(mk(1, 4, 52)));
      check("t3_beats",     64'(out_beats),           64'(6));
      check("t3_term_once", 64'(term_cnt - term_base), 64'(1));
      take_out();

      // 4: tmax gating, T == tmax is excluded; in_valid in IDLE not accepted
      in_valid = 1'b1;
      in_hits  = beat4(mk(1, 1, 99), none, none, none);
      tick();
      check("t4_idle_in_ready", 64'(in_ready), 64'(0));
      in_valid = 1'b0;
      start_job(1'b0, fixed_t'(10 * 65536));
      send_beat(beat4(mk(1, 10, 70), mk(1, 11, 71), none, none), 1'b1);
      wait_out("t4");
      check("t4_hit",   64'(out_hit),   64'(no_hit()));
      check("t4_beats", 64'(out_beats), 64'(1));
      take_out();

      // 5: output backpressure; start request in DONE is not acknowledged
      start_job(1'b0, inf_t);
      send_beat(beat4(none, mk(1, 9, 80), none, none), 1'b1);
      wait_out("t5");
      start_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("t5_hold_hit",     64'(out_hit),     64'(mk(1, 9, 80)));
         check("t5_hold_valid",   64'(out_valid),   64'(1));
         check("t5_hold_start",   64'(start_ready), 64'(0));
         check("t5_hold_in_rdy",  64'(in_ready),    64'(0));
         tick();
      end
      start_valid = 1'b0;
      take_out();
      check("t5_idle_start_rdy", 64'(start_ready), 64'(1));
      check("t5_idle_out_valid", 64'(out_valid),   64'(0));

      // 6: async reset mid-ACCUM abandons the job
      term_base = term_cnt;
      start_job(1'b1, inf_t);
      send_beat(beat4(mk(1, 1, 90), none, none, none), 1'b0);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_start_rdy", 64'(start_ready), 64'(1));
      check("t6_rst_out_valid", 64'(out_valid),   64'(0));
      check("t6_rst_in_ready",  64'(in_ready),    64'(0));
      check("t6_rst_beats",     64'(out_beats),   64'(0));
      tick();
      reset = 1'b0;
      tick();
      check("t6_no_term", 64'(term_cnt - term_base), 64'(0));
      start_job(1'b0, inf_t);
      send_beat(beat4(none, none, none, mk(1, 6, 91)), 1'b1);
      wait_out("t6");
      check("t6_hit",   64'(out_hit),   64'(mk(1, 6, 91)));
      check("t6_beats", 64'(out_beats), 64'(1));
      take_out();

      // 7: beat counter saturates at all-ones
      start_job(1'b0, inf_t);
      for (int i = 0; i < 260; i++) begin
         send_beat(beat4(none, none, none, none), (i == 259));
      end
      wait_out("t7");
      check("t7_beats_sat", 64'(out_beats), 64'(255));
      check("t7_hit",       64'(out_hit),   64'(no_hit()));
      take_out();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
